// File: rtl/branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolver_pkg
// Shared definitions for the branch resolver slice: instruction address width,
// the all-zero word, resolver FSM state encodings and the layout of one tracked
// branch entry (PC, predicted direction, predicted target).
// -----------------------------------------------------------------------------
package branch_resolver_pkg;

   localparam int INST_ADDR_W = 32;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;

   localparam inst_addr_t ZERO_WORD = '0;

   typedef enum logic {
      RESOLVER_NORMAL  = 1'b0,
      RESOLVER_RECOVER = 1'b1
   } resolver_state_t;

   typedef struct packed {
      inst_addr_t pc;
      logic       taken;
      inst_addr_t target;
   } branch_entry_t;

   localparam int ENTRY_W = $bits(branch_entry_t);

   // Sequential fetch address after a branch that is not taken.
   function automatic inst_addr_t fallthrough_pc(input inst_addr_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// -----------------------------------------------------------------------------
// branch_resolver_if
// Bundles the three sides of the resolver:
//   push_*     : IF issues a predicted branch (valid/ready handshake)
//   resolve_*  : EX resolves the oldest in-flight branch
//   outputs    : predictor training (update_predict, predict_success,
//                last_branch_pc), pipeline flush/redirect, resolve_err and
//                queue occupancy (in_flight)
// Modports: slave = resolver side, master = driver side (IF/EX/testbench).
// -----------------------------------------------------------------------------
interface branch_resolver_if #(
   parameter int PTR_W = 2
);
   import branch_resolver_pkg::*;

   logic       push_valid;
   logic       push_ready;
   inst_addr_t push_pc;
   logic       push_taken;
   inst_addr_t push_target;

   logic       resolve_valid;
   logic       resolve_taken;
   inst_addr_t resolve_target;

   logic       update_predict;
   logic       predict_success;
   inst_addr_t last_branch_pc;
   logic       flush;
   inst_addr_t redirect_pc;
   logic       resolve_err;
   logic [PTR_W:0] in_flight;

   modport slave (
      input  push_valid, push_pc, push_taken, push_target,
      input  resolve_valid, resolve_taken, resolve_target,
      output push_ready,
      output update_predict, predict_success, last_branch_pc,
      output flush, redirect_pc, resolve_err, in_flight
   );

   modport master (
      output push_valid, push_pc, push_taken, push_target,
      output resolve_valid, resolve_taken, resolve_target,
      input  push_ready,
      input  update_predict, predict_success, last_branch_pc,
      input  flush, redirect_pc, resolve_err, in_flight
   );

endinterface

// File: rtl/branch_resolver_fifo.sv
// -----------------------------------------------------------------------------
// branch_info_fifo
// In-order circular buffer of predicted branches.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write one entry (ignored when full without a pop)
//   pop               : retire the head entry (ignored when empty)
//   clear             : drop every entry; wins over push/pop in the same cycle
//   head              : oldest entry, valid when !empty
//   count, full, empty: occupancy status
// -----------------------------------------------------------------------------
module branch_info_fifo
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  branch_entry_t push_data,
   input  logic          pop,
   input  logic          clear,
   output branch_entry_t head,
   output logic [PTR_W:0] count,
   output logic          full,
   output logic          empty
);

   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic               push_ok;
   logic               pop_ok;

   // A push at full is only legal when the head leaves in the same cycle.
   always_comb begin
      full    = (count == FULL_CNT);
      empty   = (count == '0);
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      head    = branch_entry_t'(mem[rd_ptr]);
   end

   // Entry storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// EX-side partner of the branch predictor. Every prediction issued at IF is
// queued in order; when EX resolves a branch it is compared with the oldest
// queued prediction and the predictor is trained. A wrong direction or a wrong
// taken-target flushes the pipeline, redirects fetch and squashes every
// younger queued prediction.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolver_if.slave (push, resolve and result signals)
// All result outputs are registered, one cycle after resolve_valid.
// -----------------------------------------------------------------------------
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   branch_resolver_if.slave  bus
);

   resolver_state_t state;
   resolver_state_t next_state;

   branch_entry_t   head;
   branch_entry_t   push_entry;
   logic [PTR_W:0]  count;
   logic            full;
   logic            empty;

   logic            resolving;
   logic            pop_req;
   logic            err_now;
   logic            dir_ok;
   logic            tgt_ok;
   logic            mispredict_now;
   logic            push_ready_c;
   logic            push_fire;
   inst_addr_t      redirect_next;

   logic            update_predict_q;
   logic            predict_success_q;
   inst_addr_t      last_branch_pc_q;
   logic            flush_q;
   inst_addr_t      redirect_pc_q;
   logic            resolve_err_q;

   branch_info_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_fire),
      .push_data (push_entry),
      .pop       (pop_req),
      .clear     (mispredict_now),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Resolve evaluation against the head entry plus the IF-side handshake.
   // A mispredict blocks pushes in the same cycle because the queue is about
   // to be cleared and anything fetched now is on the wrong path.
   always_comb begin
      push_entry.pc     = bus.push_pc;
      push_entry.taken  = bus.push_taken;
      push_entry.target = bus.push_target;

      dir_ok         = (bus.resolve_taken == head.taken);
      tgt_ok         = !bus.resolve_taken || (bus.resolve_target == head.target);
      resolving      = bus.resolve_valid && (state == RESOLVER_NORMAL);
      pop_req        = resolving && !empty;
      err_now        = resolving && empty;
      mispredict_now = pop_req && !(dir_ok && tgt_ok);
      redirect_next  = bus.resolve_taken ? bus.resolve_target : fallthrough_pc(head.pc);

      push_ready_c   = (!full || pop_req) && (state == RESOLVER_NORMAL) && !mispredict_now;
      push_fire      = bus.push_valid && push_ready_c;
   end

   // Next-state logic: RECOVER covers the single flush cycle.
   always_comb begin
      next_state = state;
      case (state)
         RESOLVER_NORMAL:  if (mispredict_now) next_state = RESOLVER_RECOVER;
         RESOLVER_RECOVER: next_state = RESOLVER_NORMAL;
         default:          next_state = RESOLVER_NORMAL;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RESOLVER_NORMAL;
      end else begin
         state <= next_state;
      end
   end

   // Registered results. Pulses are recomputed every cycle so they drop on
   // their own; the PC outputs hold their last loaded value.
   always_ff @(posedge clk) begin
      if (rst) begin
         update_predict_q  <= 1'b0;
         predict_success_q <= 1'b0;
         last_branch_pc_q  <= ZERO_WORD;
         flush_q           <= 1'b0;
         redirect_pc_q     <= ZERO_WORD;
         resolve_err_q     <= 1'b0;
      end else begin
         update_predict_q  <= pop_req;
         predict_success_q <= pop_req && dir_ok;
         flush_q           <= mispredict_now;
         resolve_err_q     <= err_now;
         if (pop_req) begin
            last_branch_pc_q <= head.pc;
         end
         if (mispredict_now) begin
            redirect_pc_q <= redirect_next;
         end
      end
   end

   assign bus.push_ready      = push_ready_c;
   assign bus.update_predict  = update_predict_q;
   assign bus.predict_success = predict_success_q;
   assign bus.last_branch_pc  = last_branch_pc_q;
   assign bus.flush           = flush_q;
   assign bus.redirect_pc     = redirect_pc_q;
   assign bus.resolve_err     = resolve_err_q;
   assign bus.in_flight       = count;

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Drives IF pushes and EX resolves cycle by cycle. A behavioural model of the
// prediction queue computes the expected result of each cycle, which is queued
// on a scoreboard and compared once the DUT's registered outputs update.
// -----------------------------------------------------------------------------
module tb_branch_resolver;
   import branch_resolver_pkg::*;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   typedef struct {
      logic       rst;
      logic       pv;
      inst_addr_t pc;
      logic       pt;
      inst_addr_t ptg;
      logic       rv;
      logic       rt;
      inst_addr_t rtg;
   } stim_t;

   typedef struct {
      logic           rst;
      logic           rdy;
      logic           upd;
      logic           succ;
      inst_addr_t     pc;
      logic           fl;
      inst_addr_t     redir;
      logic           err;
      logic [PTR_W:0] cnt;
   } exp_t;

   logic clk;
   logic rst;

   int checks;
   int errors;

   exp_t          sb[$];
   branch_entry_t mq[$];
   logic          m_recover;
   logic          obs_rdy;

   branch_resolver_if #(.PTR_W(PTR_W)) bus ();

   branch_resolver #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard bound on total run time.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One cycle: drive inputs, sample push_ready, predict the registered
   // outcome with the model and queue it, then advance past the clock edge.
   task automatic drive_cycle(input stim_t s);
      exp_t          e;
      branch_entry_t h;
      branch_entry_t n;
      logic          pop;
      logic          mis;
      logic          dir;
      logic          tgt;

      rst               = s.rst;
      bus.push_valid    = s.pv;
      bus.push_pc       = s.pc;
      bus.push_taken    = s.pt;
      bus.push_target   = s.ptg;
      bus.resolve_valid = s.rv;
      bus.resolve_taken = s.rt;
      bus.resolve_target = s.rtg;
      #1;
      obs_rdy = bus.push_ready;

      pop     = 1'b0;
      mis     = 1'b0;
      e.rst   = 1'b0;
      e.upd   = 1'b0;
      e.succ  = 1'b0;
      e.pc    = 32'h0;
      e.fl    = 1'b0;
      e.redir = 32'h0;
      e.err   = 1'b0;
      if (!m_recover && s.rv) begin
         if (mq.size() == 0) begin
            e.err = 1'b1;
         end else begin
            h      = mq[0];
            dir    = (s.rt == h.taken);
            tgt    = !s.rt || (s.rtg == h.target);
            pop    = 1'b1;
            mis    = !(dir && tgt);
            e.upd  = 1'b1;
            e.succ = dir;
            e.pc   = h.pc;
            e.fl   = mis;
            e.redir = s.rt ? s.rtg : h.pc + 32'd4;
         end
      end
      e.rdy = !m_recover && ((mq.size() < DEPTH) || pop) && !mis;

      if (s.rst) begin
         mq.delete();
         m_recover = 1'b0;
         e.rst   = 1'b1;
         e.upd   = 1'b0;
         e.succ  = 1'b0;
         e.pc    = 32'h0;
         e.fl    = 1'b0;
         e.redir = 32'h0;
         e.err   = 1'b0;
      end else begin
         if (mis) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (s.pv && e.rdy) begin
               n.pc     = s.pc;
               n.taken  = s.pt;
               n.target = s.ptg;
               mq.push_back(n);
            end
         end
         m_recover = mis;
      end
      e.cnt = mq.size();
      sb.push_back(e);

      @(posedge clk);
      #1;
      rst               = 1'b0;
      bus.push_valid    = 1'b0;
      bus.resolve_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst               = 1'b1;
      bus.push_valid    = 1'b0;
      bus.push_pc       = 32'h0;
      bus.push_taken    = 1'b0;
      bus.push_target   = 32'h0;
      bus.resolve_valid = 1'b0;
      bus.resolve_taken = 1'b0;
      bus.resolve_target = 32'h0;
      m_recover = 1'b0;
      mq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++; if (bus.update_predict !== 1'b0) begin errors++; $display("[TB] FAIL reset update_predict: got %b want 0", bus.update_predict); end
      checks++; if (bus.predict_success !== 1'b0) begin errors++; $display("[TB] FAIL reset predict_success: got %b want 0", bus.predict_success); end
      checks++; if (bus.flush !== 1'b0) begin errors++; $display("[TB] FAIL reset flush: got %b want 0", bus.flush); end
      checks++; if (bus.resolve_err !== 1'b0) begin errors++; $display("[TB] FAIL reset resolve_err: got %b want 0", bus.resolve_err); end
      checks++; if (bus.last_branch_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset last_branch_pc: got %h want 0", bus.last_branch_pc); end
      checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset redirect_pc: got %h want 0", bus.redirect_pc); end
      checks++; if (bus.in_flight !== 3'd0) begin errors++; $display("[TB] FAIL reset in_flight: got %0d want 0", bus.in_flight); end
      checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset push_ready: got %b want 1", bus.push_ready); end
   endtask

   // Runs a stimulus table and compares every scoreboard entry.
   task automatic test_table(input string name, input stim_t s[$]);
      exp_t e;
      foreach (s[i]) begin
         drive_cycle(s[i]);
         e = sb.pop_front();
         checks++; if (obs_rdy !== e.rdy) begin errors++; $display("[TB] FAIL %s push_ready row %0d: got %b want %b", name, i, obs_rdy, e.rdy); end
         checks++; if (bus.update_predict !== e.upd) begin errors++; $display("[TB] FAIL %s update_predict row %0d: got %b want %b", name, i, bus.update_predict, e.upd); end
         if (e.upd) begin
            checks++; if (bus.predict_success !== e.succ) begin errors++; $display("[TB] FAIL %s predict_success row %0d: got %b want %b", name, i, bus.predict_success, e.succ); end
         end
         if (e.upd || e.rst) begin
            checks++; if (bus.last_branch_pc !== e.pc) begin errors++; $display("[TB] FAIL %s last_branch_pc row %0d: got %h want %h", name, i, bus.last_branch_pc, e.pc); end
         end
         checks++; if (bus.flush !== e.fl) begin errors++; $display("[TB] FAIL %s flush row %0d: got %b want %b", name, i, bus.flush, e.fl); end
         if (e.fl || e.rst) begin
            checks++; if (bus.redirect_pc !== e.redir) begin errors++; $display("[TB] FAIL %s redirect_pc row %0d: got %h want %h", name, i, bus.redirect_pc, e.redir); end
         end
         checks++; if (bus.resolve_err !== e.err) begin errors++; $display("[TB] FAIL %s resolve_err row %0d: got %b want %b", name, i, bus.resolve_err, e.err); end
         checks++; if (bus.in_flight !== e.cnt) begin errors++; $display("[TB] FAIL %s in_flight row %0d: got %0d want %0d", name, i, bus.in_flight, e.cnt); end
      end
   endtask

   task automatic test_correct_not_taken();
      stim_t s[$];
      s.push_back('{1'b0, 1'b1, 32'h100, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0});
      test_table("correct_nt", s);
   endtask

   task automatic test_direction_miss();
      stim_t s[$];
      s.push_back('{1'b0, 1'b1, 32'h200, 1'b0, 32'h204, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h180});
      s.push_back('{1'b0, 1'b1, 32'h777, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0});
      test_table("dir_miss", s);
   endtask

   task automatic test_target_miss();
      stim_t s[$];
      s.push_back('{1'b0, 1'b1, 32'h300, 1'b1, 32'h340, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h380});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0});
      test_table("tgt_miss", s);
   endtask

   task automatic test_back_to_back_full_wrap();
      stim_t s[$];
      s.push_back('{1'b0, 1'b1, 32'h10, 1'b0, 32'h14, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h14, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h18, 1'b0, 32'h1C, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h1C, 1'b0, 32'h20, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h99, 1'b0, 32'h9D, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h20, 1'b0, 32'h24, 1'b1, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'h50});
      s.push_back('{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0});
      test_table("full_wrap", s);
   endtask

   task automatic test_squash();
      stim_t s[$];
      s.push_back('{1'b0, 1'b1, 32'h500, 1'b0, 32'h504, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h504, 1'b0, 32'h508, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h508, 1'b0, 32'h50C, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h600, 1'b0, 32'h604, 1'b1, 1'b1, 32'h400});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0});
      test_table("squash", s);
   endtask

   task automatic test_empty_resolve_and_reset();
      stim_t s[$];
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h44});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h800, 1'b0, 32'h804, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b0, 1'b1, 32'h804, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0});
      s.push_back('{1'b1, 1'b1, 32'h808, 1'b0, 32'h80C, 1'b1, 1'b1, 32'h123});
      s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0});
      test_table("empty_rst", s);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_correct_not_taken();
      test_direction_miss();
      test_target_miss();
      test_back_to_back_full_wrap();
      test_squash();
      test_empty_resolve_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
